// File: rtl/cmd_paralelo_serial.sv
// Parallel-to-serial transmitter for the SD CMD line: loads an n-bit frame, shifts it out MSB-first.
// Optional macro CMD_CRC7_EN replaces frame bits 7..1 with a serially computed CRC7 and forces the end bit.
module cmd_paralelo_serial #(
    parameter int n = 48
) (
    input  logic         sd_clock,
    input  logic         reset,
    input  logic         start,
    input  logic [n-1:0] parallel,
    output logic         serial,
    output logic         cmd_oe,
    output logic         ready,
    output logic         busy,
    output logic         complete,
    output logic [6:0]   count
);

    localparam logic [6:0] LAST = 7'(n - 1);
    localparam int         IW   = $clog2(n);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t       state, state_nx;
    logic [n-1:0] shreg;
    logic [6:0]   idx_nx;
    logic         bit_nx;
    logic         serial_nx, oe_nx, ready_nx, busy_nx, complete_nx;
    logic [6:0]   count_nx;

    // Frame index driven after the next edge while shifting.
    assign idx_nx = LAST - 7'd1 - count;

`ifdef CMD_CRC7_EN
    logic [6:0] crc, crc_nx;
    logic [6:0] idx_cur;
    logic       fb;

    assign idx_cur = LAST - count;
    assign fb      = serial ^ crc[6];

    // Fold in the bit on the line while it is a payload bit, otherwise shift the CRC out.
    always_comb begin
        crc_nx = {crc[5:0], 1'b0};
        if (idx_cur >= 7'd8)
            crc_nx = {crc[5:3], crc[2] ^ fb, crc[1:0], fb};
    end

    always_comb begin
        bit_nx = 1'b1;
        if (idx_nx >= 7'd8)
            bit_nx = shreg[idx_nx[IW-1:0]];
        else if (idx_nx != 7'd0)
            bit_nx = crc_nx[6];
    end

    always_ff @(posedge sd_clock) begin
        if (reset)
            crc <= '0;
        else if (state == IDLE && start)
            crc <= '0;
        else if (state == SHIFT && count != LAST)
            crc <= crc_nx;
    end
`else
    assign bit_nx = shreg[idx_nx[IW-1:0]];
`endif

    always_ff @(posedge sd_clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = SHIFT;
            SHIFT:   if (count == LAST) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        serial_nx   = 1'b1;
        oe_nx       = 1'b0;
        ready_nx    = 1'b0;
        busy_nx     = 1'b0;
        complete_nx = 1'b0;
        count_nx    = 7'd0;
        case (state)
            IDLE: begin
                if (start) begin
                    serial_nx = parallel[n-1];
                    oe_nx     = 1'b1;
                    busy_nx   = 1'b1;
                end else begin
                    ready_nx  = 1'b1;
                end
            end
            SHIFT: begin
                if (count != LAST) begin
                    serial_nx = bit_nx;
                    oe_nx     = 1'b1;
                    busy_nx   = 1'b1;
                    count_nx  = count + 7'd1;
                end else begin
                    complete_nx = 1'b1;
                end
            end
            DONE:    ready_nx = 1'b1;
            default: ready_nx = 1'b1;
        endcase
    end

    always_ff @(posedge sd_clock) begin
        if (reset) begin
            serial   <= 1'b1;
            cmd_oe   <= 1'b0;
            ready    <= 1'b1;
            busy     <= 1'b0;
            complete <= 1'b0;
            count    <= 7'd0;
            shreg    <= '0;
        end else begin
            serial   <= serial_nx;
            cmd_oe   <= oe_nx;
            ready    <= ready_nx;
            busy     <= busy_nx;
            complete <= complete_nx;
            count    <= count_nx;
            if (state == IDLE && start)
                shreg <= parallel;
        end
    end

endmodule

// File: tb/tb_cmd_paralelo_serial.sv
// Directed bench for cmd_paralelo_serial: frame vectors, back-to-back, mid-frame changes, mid-frame reset.
module tb_cmd_paralelo_serial;

    localparam int N = 48;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [N-1:0] parallel;
    logic         serial, cmd_oe, ready, busy, complete;
    logic [6:0]   count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [N-1:0] par;
        logic [N-1:0] exp;
    } vec_t;

`ifdef CMD_CRC7_EN
    localparam int NV = 2;
    localparam logic [N-1:0] P_B2B = 48'h48_0000_01AA_00;
    localparam logic [N-1:0] E_B2B = 48'h48_0000_01AA_87;
    localparam logic [N-1:0] P_MID = 48'h40_0000_0000_00;
    localparam logic [N-1:0] E_MID = 48'h40_0000_0000_95;
`else
    localparam int NV = 5;
    localparam logic [N-1:0] P_B2B = 48'h48_0000_01AA_87;
    localparam logic [N-1:0] E_B2B = 48'h48_0000_01AA_87;
    localparam logic [N-1:0] P_MID = 48'hA5A5_5A5A_C3C3;
    localparam logic [N-1:0] E_MID = 48'hA5A5_5A5A_C3C3;
`endif

    vec_t vecs [NV];

    always #5 clk = ~clk;

    cmd_paralelo_serial #(.n(N)) dut (
        .sd_clock (clk),
        .reset    (reset),
        .start    (start),
        .parallel (parallel),
        .serial   (serial),
        .cmd_oe   (cmd_oe),
        .ready    (ready),
        .busy     (busy),
        .complete (complete),
        .count    (count)
    );

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Samples N frame cycles starting at the current sample point; ends on the DONE cycle.
    // With perturb set, parallel flips at bit 10 and start pulses at bits 5 and 20.
    task automatic capture(input bit perturb, output logic [N-1:0] f, output int oe_n, output int bad);
        oe_n = 0;
        bad  = 0;
        for (int i = 0; i < N; i++) begin
            f[N-1-i] = serial;
            if (cmd_oe === 1'b1) oe_n++;
            if (count !== 7'(i) || busy !== 1'b1 || ready !== 1'b0 || complete !== 1'b0) bad++;
            if (perturb) begin
                if (i == 10) parallel = ~parallel;
                start = (i == 5 || i == 20);
            end
            step();
        end
        start = 1'b0;
    endtask

    logic [N-1:0] f;
    int oe_n, bad, seen;

    initial begin
`ifdef CMD_CRC7_EN
        vecs[0] = '{48'h40_0000_0000_00, 48'h40_0000_0000_95};
        vecs[1] = '{48'h48_0000_01AA_00, 48'h48_0000_01AA_87};
`else
        vecs[0] = '{48'h40_0000_0000_95, 48'h40_0000_0000_95};
        vecs[1] = '{48'h48_0000_01AA_87, 48'h48_0000_01AA_87};
        vecs[2] = '{48'hFFFF_FFFF_FFFF, 48'hFFFF_FFFF_FFFF};
        vecs[3] = '{48'h8000_0000_0001, 48'h8000_0000_0001};
        vecs[4] = '{48'hA5A5_5A5A_C3C3, 48'hA5A5_5A5A_C3C3};
`endif
        reset    = 1'b1;
        start    = 1'b0;
        parallel = '0;
        repeat (3) step();
        reset = 1'b0;
        // {complete, cmd_oe, serial, ready, busy}
        check("reset_outputs", {complete, cmd_oe, serial, ready, busy}, 5'b00110);
        check("reset_count", count, 7'd0);
        step();
        check("idle_after_reset", {complete, cmd_oe, serial, ready, busy}, 5'b00110);

        for (int v = 0; v < NV; v++) begin
            parallel = vecs[v].par;
            start    = 1'b1;
            step();
            start = 1'b0;
            capture(1'b0, f, oe_n, bad);
            check($sformatf("frame%0d_bits", v), f, vecs[v].exp);
            check($sformatf("frame%0d_oe_cycles", v), oe_n, N);
            check($sformatf("frame%0d_shift_flags", v), bad, 0);
            check($sformatf("frame%0d_done", v), {complete, cmd_oe, serial, ready, busy, count}, {5'b10100, 7'd0});
            step();
            check($sformatf("frame%0d_ready", v), {complete, cmd_oe, serial, ready, busy, count}, {5'b00110, 7'd0});
        end

        // Back-to-back frames with start held high.
        parallel = P_B2B;
        start    = 1'b1;
        step();
        capture(1'b0, f, oe_n, bad);
        start = 1'b1;
        check("b2b_frame1", f, E_B2B);
        check("b2b_gap1", {cmd_oe, serial, complete}, 3'b011);
        step();
        check("b2b_gap2", {cmd_oe, serial, ready}, 3'b011);
        step();
        check("b2b_restart", {cmd_oe, busy, ready}, 3'b110);
        start = 1'b0;
        capture(1'b0, f, oe_n, bad);
        check("b2b_frame2", f, E_B2B);
        check("b2b_frame2_oe", oe_n, N);
        step();

        // parallel changes and start pulses during SHIFT must not disturb the frame.
        parallel = P_MID;
        start    = 1'b1;
        step();
        start = 1'b0;
        capture(1'b1, f, oe_n, bad);
        check("mid_frame_bits", f, E_MID);
        check("mid_frame_flags", bad, 0);
        step();
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (cmd_oe !== 1'b0 || ready !== 1'b1) seen++;
            step();
        end
        check("mid_no_extra_frame", seen, 0);

        // Reset in the middle of a frame aborts it silently.
        parallel = 48'hFFFF_0000_FFFF;
        start    = 1'b1;
        step();
        start = 1'b0;
        repeat (20) step();
        check("pre_reset_count", {cmd_oe, count}, {1'b1, 7'd20});
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_outputs", {complete, cmd_oe, serial, ready, busy, count}, {5'b00110, 7'd0});
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (complete !== 1'b0 || cmd_oe !== 1'b0) seen++;
            step();
        end
        check("abort_no_complete", seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cmd_paralelo_serial.md
Name: cmd_paralelo_serial

Overview:
Parallel-to-serial transmitter for the SD host CMD line. It is the transmit-side counterpart of the CMD serial-to-parallel receiver in capa_fisica. It takes a complete N-bit command frame in one cycle, then shifts it out MSB-first, one bit per sd_clock. It drives the CMD output-enable and pulses complete when the frame has been sent.

Parameters:
n, 48, frame length in bits; legal range 16..64.

Ports:
sd_clock  input  1  SD clock; all logic updates on its rising edge
reset  input  1  synchronous reset, active-high
start  input  1  request to transmit; sampled only while ready=1
parallel  input  n  frame to send; bit n-1 is sent first
serial  output  1  CMD line data; idles at 1
cmd_oe  output  1  CMD pad output-enable; 1 while a frame bit is driven
ready  output  1  1 in IDLE; a start is accepted this cycle
busy  output  1  1 while frame bits are being shifted
complete  output  1  one-cycle pulse after the last bit
count  output  7  index of the bit currently driven (0..n-1); 0 when not shifting

Behaviour:
- All outputs are registered, and all state changes on posedge sd_clock.
- Reset (synchronous, highest priority, also mid-frame):
  - state=IDLE, serial=1, cmd_oe=0, ready=1, busy=0, complete=0, count=0, shift register=0.
  - A frame in progress is aborted with no complete pulse.
- State IDLE:
  - serial=1, cmd_oe=0, ready=1.
  - If start=1 at edge k: load shift register from parallel, set serial<=parallel[n-1], cmd_oe<=1, busy<=1, ready<=0, count<=0, go to SHIFT.
  - First bit is therefore visible after edge k (one-cycle latency).
- State SHIFT:
  - serial = shreg[n-1-count] at every edge.
  - While count != n-1: count<=count+1 and drive the next bit.
  - When count == n-1: serial<=1, cmd_oe<=0, busy<=0, complete<=1, count<=0, go to DONE.
  - Each bit is driven for exactly 1 cycle; a frame occupies n consecutive cycles of cmd_oe=1.
- State DONE:
  - Lasts one cycle with complete=1, serial=1, cmd_oe=0.
  - Next edge: complete<=0, ready<=1, go to IDLE.
- start is ignored in SHIFT and DONE; no queuing.
- The minimum gap between frames is 2 idle-high cycles (DONE, then the IDLE cycle in which start is sampled).
- parallel is sampled only at the accepting edge; later changes do not affect the frame in flight.
- count arithmetic is unsigned 7-bit, with no wrap beyond n-1.

Optional Feature:
CMD_CRC7_EN
- Defined:
  - During SHIFT, a CRC7 (poly x^7+x^3+1, initial value 0) is computed serially over bits n-1 down to 8 as they are sent.
  - The 7 CRC bits replace frame bits 7..1, which are sent from the CRC register MSB-first.
  - Bit 0 is forced to 1 (end bit); parallel[7:0] is ignored.
  - The CRC register clears on reset and on frame acceptance.
- Not defined:
  - All n bits are sent verbatim from parallel; no CRC logic is instantiated.

Test Plan:
- Reset held 3 cycles, released -> serial=1, cmd_oe=0, ready=1, busy=0, complete=0, count=0.
- n=48, parallel=48'h40_0000_0000_95, start pulsed 1 cycle:
  - serial emits 0,1,0,0,0,0,0,0, then 32 zeros, then 1,0,0,1,0,1,0,1 on the 48 cycles after the accept edge.
  - cmd_oe=1 for exactly those 48 cycles.
  - complete=1 on cycle 49 only; ready=1 on cycle 50.
- start held high continuously with parallel=48'h48_0000_01AA_87:
  - Back-to-back frames are separated by exactly 2 cycles with serial=1 and cmd_oe=0.
  - Each frame is bit-exact.
- Mid-frame change of parallel (cycle 10) and start=1 pulses during SHIFT -> the transmitted frame equals the value captured at acceptance; no extra frame starts.
- Reset asserted at bit 20 of a frame -> next cycle serial=1, cmd_oe=0, ready=1, count=0; no complete pulse.
- With CMD_CRC7_EN: parallel=48'h40_0000_0000_00 -> last byte sent is 8'h95; parallel=48'h48_0000_01AA_00 -> last byte sent is 8'h87.
